// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-bus request/response handshake between fetch and memory
interface fetch_stage_if;
    logic        ibus_valid;
    logic [31:0] ibus_addr;
    logic        ibus_addr_ok;
    logic        ibus_data_ok;
    logic [31:0] ibus_data;
    modport master (output ibus_valid, ibus_addr, input ibus_addr_ok, ibus_data_ok, ibus_data);
    modport slave  (input ibus_valid, ibus_addr, output ibus_addr_ok, ibus_data_ok, ibus_data);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage owning the PC, one outstanding ibus read, filling the F->D register
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          br_taken,
    input  logic [31:0]   br_target,
    input  logic          flush,
    input  logic [31:0]   flush_pc,
    fetch_stage_if.master ibus,
    output logic          d_valid,
    output logic [31:0]   d_pc,
    output logic [31:0]   d_instr,
    output logic          d_adel
);
    typedef enum logic [1:0] {REQ, WAIT, HOLD, IDLE} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, br_tgt_q, br_tgt_d, buf_q, buf_d, dis_addr_q, dis_addr_d;
    logic        pend_br_q, pend_br_d, discard_q, discard_d;
    logic        d_valid_q, d_valid_d, d_adel_q, d_adel_d;
    logic [31:0] d_pc_q, d_pc_d, d_instr_q, d_instr_d;
    logic        misaligned, d_free, br_now, accept, resp, outstanding;
    logic [31:0] next_pc, word;

    // A discarded request keeps presenting its original address until accepted
    assign misaligned      = pc_q[1:0] != 2'b00;
    assign ibus.ibus_valid = !reset && state_q == REQ && (discard_q || !misaligned);
    assign ibus.ibus_addr  = discard_q ? dis_addr_q : pc_q;
    assign d_free          = !d_valid_q || !stall;
    assign br_now          = d_valid_q && !stall && !flush && br_taken;
    assign next_pc         = (pend_br_q || br_now) ? (br_now ? br_target : br_tgt_q) : pc_q + 32'd4;
    assign accept          = ibus.ibus_valid && ibus.ibus_addr_ok;
    assign resp            = (state_q == WAIT || accept) && ibus.ibus_data_ok;
    assign outstanding     = (state_q == WAIT || accept) && !ibus.ibus_data_ok;
    assign word            = state_q == HOLD ? buf_q : ibus.ibus_data;
    assign d_valid         = d_valid_q;
    assign d_pc            = d_pc_q;
    assign d_instr         = d_instr_q;
    assign d_adel          = d_adel_q;

    // Next state: flush wins, then draining a discarded response, then normal fetch/deliver
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        buf_d      = buf_q;
        dis_addr_d = dis_addr_q;
        discard_d  = discard_q;
        pend_br_d  = pend_br_q || br_now;
        br_tgt_d   = br_now ? br_target : br_tgt_q;
        d_valid_d  = d_valid_q && !d_free;
        d_pc_d     = d_pc_q;
        d_instr_d  = d_instr_q;
        d_adel_d   = d_adel_q;
        if (flush) begin
            state_d    = outstanding ? WAIT : REQ;
            pc_d       = flush_pc;
            pend_br_d  = 1'b0;
            d_valid_d  = 1'b0;
            discard_d  = outstanding || (ibus.ibus_valid && !ibus.ibus_addr_ok);
            dis_addr_d = ibus.ibus_addr;
        end else if (discard_q) begin
            state_d   = resp ? REQ : (accept ? WAIT : state_q);
            discard_d = !resp;
        end else if (state_q == REQ && misaligned) begin
            if (d_free) begin
                d_valid_d = 1'b1;
                d_pc_d    = pc_q;
                d_instr_d = '0;
                d_adel_d  = 1'b1;
                state_d   = IDLE;
            end
        end else if (resp || state_q == HOLD) begin
            if (d_free) begin
                d_valid_d = 1'b1;
                d_pc_d    = pc_q;
                d_instr_d = word;
                d_adel_d  = 1'b0;
                pc_d      = next_pc;
                pend_br_d = 1'b0;
                state_d   = REQ;
            end else begin
                buf_d   = word;
                state_d = HOLD;
            end
        end else if (accept) begin
            state_d = WAIT;
        end
    end

    // Register update with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= REQ;
            pc_q       <= RESET_PC;
            buf_q      <= '0;
            dis_addr_q <= '0;
            discard_q  <= 1'b0;
            pend_br_q  <= 1'b0;
            br_tgt_q   <= '0;
            d_valid_q  <= 1'b0;
            d_pc_q     <= '0;
            d_instr_q  <= '0;
            d_adel_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            buf_q      <= buf_d;
            dis_addr_q <= dis_addr_d;
            discard_q  <= discard_d;
            pend_br_q  <= pend_br_d;
            br_tgt_q   <= br_tgt_d;
            d_valid_q  <= d_valid_d;
            d_pc_q     <= d_pc_d;
            d_instr_q  <= d_instr_d;
            d_adel_q   <= d_adel_d;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a program-order model
module tb_fetch_stage;
    logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, br_taken = 1'b0, flush = 1'b0;
    logic [31:0] br_target = '0, flush_pc = '0;
    logic        d_valid, d_adel;
    logic [31:0] d_pc, d_instr;

    fetch_stage_if bus();

    fetch_stage #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .flush(flush), .flush_pc(flush_pc), .ibus(bus),
        .d_valid(d_valid), .d_pc(d_pc), .d_instr(d_instr), .d_adel(d_adel)
    );

    always #5 clk = ~clk;

    int          n_vec = 0, n_err = 0, n_del = 0;
    int          lat_fixed = 0, aok_pct = 100, accepts = 0, cnt = 0;
    logic        busy = 1'b0, prev_req = 1'b0;
    logic [31:0] out_addr = '0, prev_addr = '0;
    logic [11:0] pat;
    logic [31:0] exp_pc, br_tgt, h_pc, h_instr;
    logic        br_pend, idle, m_flush, m_hold, m_free, h_adel;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // memory-side responder: random or fixed accept and latency, one request at a time
    task automatic bus_drive();
        bus.ibus_addr_ok = 1'b0;
        bus.ibus_data_ok = 1'b0;
        bus.ibus_data    = 32'hDEAD_BEEF;
        if (prev_req) begin
            chk("addr_held_valid", 32'(bus.ibus_valid), 32'd1);
            chk("addr_held", bus.ibus_addr, prev_addr);
        end
        if (busy) begin
            chk("one_outstanding", 32'(bus.ibus_valid), 32'd0);
            if (cnt == 0) begin
                bus.ibus_data_ok = 1'b1;
                bus.ibus_data    = mem(out_addr);
                busy             = 1'b0;
            end else cnt--;
        end else if (bus.ibus_valid && $urandom_range(0, 99) < aok_pct) begin
            int l;
            l = lat_fixed >= 0 ? lat_fixed : int'($urandom_range(0, 3));
            bus.ibus_addr_ok = 1'b1;
            accepts++;
            out_addr = bus.ibus_addr;
            if (l == 0) begin
                bus.ibus_data_ok = 1'b1;
                bus.ibus_data    = mem(out_addr);
            end else begin
                busy = 1'b1;
                cnt  = l - 1;
            end
        end
        prev_req  = bus.ibus_valid && !bus.ibus_addr_ok;
        prev_addr = bus.ibus_addr;
    endtask

    // one clock: respond on the bus, advance the program-order model, check what D shows
    task automatic tick();
        #1;
        bus_drive();
        m_flush = flush;
        m_hold  = d_valid && stall && !flush;
        m_free  = !flush && (!d_valid || !stall);
        h_pc    = d_pc;
        h_instr = d_instr;
        h_adel  = d_adel;
        if (flush) begin
            exp_pc  = flush_pc;
            br_pend = 1'b0;
            idle    = 1'b0;
        end else if (d_valid && !stall && br_taken) begin
            br_pend = 1'b1;
            br_tgt  = br_target;
        end
        @(posedge clk);
        @(negedge clk);
        if (m_flush) chk("flush_clears_d", 32'(d_valid), 32'd0);
        else if (m_hold) begin
            chk("stall_hold_valid", 32'(d_valid), 32'd1);
            chk("stall_hold_pc", d_pc, h_pc);
            chk("stall_hold_instr", d_instr, h_instr);
            chk("stall_hold_adel", 32'(d_adel), 32'(h_adel));
        end else if (m_free && d_valid) begin
            n_del++;
            chk("no_fetch_when_idle", 32'(idle), 32'd0);
            chk("d_pc", d_pc, exp_pc);
            chk("d_adel", 32'(d_adel), 32'(exp_pc[1:0] != 2'b00));
            chk("d_instr", d_instr, exp_pc[1:0] != 2'b00 ? 32'd0 : mem(exp_pc));
            if (exp_pc[1:0] != 2'b00) idle = 1'b1;
            else begin
                exp_pc  = br_pend ? br_tgt : exp_pc + 32'd4;
                br_pend = 1'b0;
            end
        end
        if (idle) chk("idle_no_request", 32'(bus.ibus_valid), 32'd0);
    endtask

    task automatic wait_deliver(input int n);
        for (int i = 0; i < n && !d_valid; i++) tick();
        chk("deliver_timeout", 32'(d_valid), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.ibus_addr_ok = 1'b0;
        bus.ibus_data_ok = 1'b0;
        bus.ibus_data    = '0;
        repeat (3) @(negedge clk);
        chk("rst_ibus_valid", 32'(bus.ibus_valid), 32'd0);
        chk("rst_d_valid", 32'(d_valid), 32'd0);
        chk("rst_d_pc", d_pc, 32'd0);
        chk("rst_d_instr", d_instr, 32'd0);
        chk("rst_d_adel", 32'(d_adel), 32'd0);
        reset   = 1'b0;
        exp_pc  = 32'hBFC0_0000;
        br_tgt  = '0;
        br_pend = 1'b0;
        idle    = 1'b0;
        tick();
        chk("zl_valid", 32'(d_valid), 32'd1);
        chk("zl_pc0", d_pc, 32'hBFC0_0000);
        tick();
        chk("zl_pc1", d_pc, 32'hBFC0_0004);
        tick();
        chk("zl_pc2", d_pc, 32'hBFC0_0008);
        tick();
        tick();
        chk("pre_stall_pc", d_pc, 32'hBFC0_0010);
        stall   = 1'b1;
        accepts = 0;
        repeat (5) tick();
        chk("stall_one_request", 32'(accepts), 32'd1);
        chk("stall_pc", d_pc, 32'hBFC0_0010);
        stall = 1'b0;
        tick();
        chk("release_pc0", d_pc, 32'hBFC0_0014);
        tick();
        chk("release_pc1", d_pc, 32'hBFC0_0018);
        lat_fixed = 3;
        for (int i = 0; i < 12; i++) begin
            tick();
            pat[i] = d_valid;
            if (i == 0) chk("lat_valid_drops", 32'(bus.ibus_valid), 32'd0);
        end
        chk("lat_pulse_pattern", 32'(pat), 32'h888);
        chk("lat_last_pc", d_pc, 32'hBFC0_0024);
        lat_fixed = 0;
        flush     = 1'b1;
        flush_pc  = 32'h100;
        tick();
        flush = 1'b0;
        tick();
        chk("br_pc0", d_pc, 32'h100);
        br_taken  = 1'b1;
        br_target = 32'h400;
        tick();
        br_taken = 1'b0;
        chk("br_slot", d_pc, 32'h104);
        tick();
        chk("br_tgt", d_pc, 32'h400);
        tick();
        chk("br_tgt4", d_pc, 32'h404);
        flush    = 1'b1;
        flush_pc = 32'h200;
        tick();
        flush = 1'b0;
        tick();
        tick();
        chk("pre_wait_pc", d_pc, 32'h204);
        lat_fixed = 3;
        tick();
        chk("wait_no_valid", 32'(bus.ibus_valid), 32'd0);
        chk("wait_addr", out_addr, 32'h208);
        flush    = 1'b1;
        flush_pc = 32'hBFC0_0380;
        tick();
        flush = 1'b0;
        chk("flush_drop_valid", 32'(d_valid), 32'd0);
        wait_deliver(20);
        chk("flush_next_pc", d_pc, 32'hBFC0_0380);
        lat_fixed = 0;
        flush     = 1'b1;
        flush_pc  = 32'h1002;
        tick();
        flush = 1'b0;
        wait_deliver(20);
        chk("adel_pc", d_pc, 32'h1002);
        chk("adel_flag", 32'(d_adel), 32'd1);
        chk("adel_instr", d_instr, 32'd0);
        repeat (4) tick();
        chk("adel_idle", 32'(bus.ibus_valid), 32'd0);
        flush    = 1'b1;
        flush_pc = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        wait_deliver(20);
        chk("wrap_pc0", d_pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc1", d_pc, 32'h0000_0000);
        lat_fixed = -1;
        aok_pct   = 60;
        n_del     = 0;
        for (int i = 0; i < 4000; i++) begin
            stall     = $urandom_range(0, 99) < 30;
            br_taken  = $urandom_range(0, 99) < 15;
            br_target = $urandom & 32'hFFFF_FFFC;
            flush     = $urandom_range(0, 99) < 3;
            flush_pc  = $urandom_range(0, 19) == 0 ? ($urandom | 32'd1) : ($urandom & 32'hFFFF_FFFC);
            tick();
        end
        stall    = 1'b0;
        br_taken = 1'b0;
        flush    = 1'b0;
        chk("random_progress", 32'(n_del > 200), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
